fetch2_cti_filter: RTL

FETCH2_CTI_FILTER -- requirements
Module: fetch2_cti_filter

---
 rtl/fetch2_cti_filter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch2_cti_filter.sv
// fetch2_cti_filter: second fetch stage filter for control-transfer instructions.
// Masks each fetch bundle after its first predicted-taken lane, hands out
// CTI queue tags to the surviving control lanes, registers the bundle for the
// next stage and raises a redirect when the taken lane missed in the BTB.
// Optional build macro FETCH2_RECOVER_REG_EN: when defined, the recover
// outputs are registered and line up with the bundle's first out_valid_o
// cycle; when undefined they are combinational in the accept cycle.
module fetch2_cti_filter #(
    parameter int FETCH_WIDTH  = 4,
    parameter int SIZE_PC      = 32,
    parameter int CTIQ_LOG     = 4,
    parameter int RETIRE_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [SIZE_PC-1:0]              pc_i,
    input  logic [FETCH_WIDTH-1:0]          isCtrl_i,
    input  logic [FETCH_WIDTH-1:0]          prediction_i,
    input  logic [FETCH_WIDTH-1:0]          btbHit_i,
    input  logic [2*FETCH_WIDTH-1:0]        ctrlType_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]  target_i,
    input  logic [SIZE_PC-1:0]              addrRAS_i,
    input  logic                            flush_i,
    input  logic [RETIRE_WIDTH-1:0]         commitCti_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [SIZE_PC-1:0]              outPC_o,
    output logic [FETCH_WIDTH-1:0]          outMask_o,
    output logic [FETCH_WIDTH*CTIQ_LOG-1:0] outTag_o,
    output logic [FETCH_WIDTH*SIZE_PC-1:0]  outTarget_o,
    output logic                            recover_o,
    output logic                            recoverRtr_o,
    output logic                            recoverCall_o,
    output logic [SIZE_PC-1:0]              recoverTarget_o,
    output logic [SIZE_PC-1:0]              callPC_o,
    output logic [CTIQ_LOG:0]               ctiqCount_o,
    output logic                            ctiqFull_o
);

    localparam int L     = CTIQ_LOG;
    localparam int PW    = CTIQ_LOG + 1;
    localparam int DEPTH = 1 << CTIQ_LOG;
    localparam int SELW  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [1:0]                     rst_sync_q;
    logic                           rst_sync_n;
    logic [PW-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]                  count_c, free_c, alloc_c, commit_c;
    logic [FETCH_WIDTH-1:0]         taken_c, mask_c;
    logic [FETCH_WIDTH*L-1:0]       tag_c;
    logic [FETCH_WIDTH*SIZE_PC-1:0] tgt_c;
    logic                           any_taken_c;
    logic [SELW-1:0]                sel_c;
    logic [1:0]                     sel_type_c;
    logic                           accept_c;
    logic                           valid_q, valid_d;
    logic [SIZE_PC-1:0]             pc_q;
    logic [FETCH_WIDTH-1:0]         mask_q;
    logic [FETCH_WIDTH*L-1:0]       tag_q;
    logic [FETCH_WIDTH*SIZE_PC-1:0] tgt_q;
    logic                           rec_c, rec_rtr_c, rec_call_c;
    logic [SIZE_PC-1:0]             rec_tgt_c, call_pc_c;

    // Reset asserts immediately, releases two clk edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_sync_n = rst_sync_q[1];

    // Per-lane decode: taken flags, mask up to first taken lane, tags, targets.
    always_comb begin
        taken_c     = '0;
        mask_c      = '0;
        tag_c       = '0;
        tgt_c       = '0;
        any_taken_c = 1'b0;
        sel_c       = '0;
        alloc_c     = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            taken_c[k] = isCtrl_i[k] & (prediction_i[k] | (ctrlType_i[2*k +: 2] != 2'b11));
            tgt_c[k*SIZE_PC +: SIZE_PC] = (ctrlType_i[2*k +: 2] == 2'b00) ?
                                          addrRAS_i : target_i[k*SIZE_PC +: SIZE_PC];
            mask_c[k] = ~any_taken_c;
            if (mask_c[k] & isCtrl_i[k]) begin
                tag_c[k*L +: L] = tail_q[L-1:0] + alloc_c[L-1:0];
                alloc_c         = alloc_c + PW'(1);
            end
            if (~any_taken_c & taken_c[k]) begin
                any_taken_c = 1'b1;
                sel_c       = SELW'(k);
            end
        end
    end

    // Number of CTIs retiring this cycle.
    always_comb begin
        commit_c = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            commit_c = commit_c + PW'(commitCti_i[i]);
        end
    end

    assign count_c    = tail_q - head_q;
    assign free_c     = PW'(DEPTH) - count_c;
    assign in_ready_o = rst_sync_n & (free_c >= PW'(FETCH_WIDTH)) &
                        (~valid_q | out_ready_i) & ~flush_i;
    assign accept_c   = in_valid_i & in_ready_o;

    // Pointer next state: commits always retire; flush drops every allocated tag.
    always_comb begin
        head_d = head_q + commit_c;
        tail_d = tail_q;
        if (flush_i)       tail_d = head_d;
        else if (accept_c) tail_d = tail_q + alloc_c;
    end

    // Head/tail pointers with wrap bit.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Output valid next state: load on accept, drop when consumed or flushed.
    always_comb begin
        valid_d = valid_q;
        if (flush_i)          valid_d = 1'b0;
        else if (accept_c)    valid_d = 1'b1;
        else if (out_ready_i) valid_d = 1'b0;
    end

    // Output bundle register; payload only changes on accept.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            mask_q  <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept_c) begin
                pc_q   <= pc_i;
                mask_q <= mask_c;
                tag_q  <= tag_c;
                tgt_q  <= tgt_c;
            end
        end
    end

    assign sel_type_c = ctrlType_i[2*sel_c +: 2];

    // Redirect on an accepted bundle whose first taken lane missed in the BTB.
    always_comb begin
        rec_c      = accept_c & any_taken_c & ~btbHit_i[sel_c];
        rec_rtr_c  = rec_c & (sel_type_c == 2'b00);
        rec_call_c = rec_c & (sel_type_c == 2'b01);
        rec_tgt_c  = rec_c ? tgt_c[sel_c*SIZE_PC +: SIZE_PC] : '0;
        call_pc_c  = rec_c ? (pc_i + (SIZE_PC'(sel_c) << 3)) : '0;
    end

`ifdef FETCH2_RECOVER_REG_EN
    logic               rec_q, rec_rtr_q, rec_call_q;
    logic [SIZE_PC-1:0] rec_tgt_q, call_pc_q;

    // Recover pulse delayed one cycle to sit on the bundle's first valid cycle.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rec_q      <= 1'b0;
            rec_rtr_q  <= 1'b0;
            rec_call_q <= 1'b0;
            rec_tgt_q  <= '0;
            call_pc_q  <= '0;
        end else begin
            rec_q      <= rec_c;
            rec_rtr_q  <= rec_rtr_c;
            rec_call_q <= rec_call_c;
            rec_tgt_q  <= rec_tgt_c;
            call_pc_q  <= call_pc_c;
        end
    end

    assign recover_o       = rec_q & ~flush_i;
    assign recoverRtr_o    = rec_rtr_q & ~flush_i;
    assign recoverCall_o   = rec_call_q & ~flush_i;
    assign recoverTarget_o = rec_tgt_q;
    assign callPC_o        = call_pc_q;
`else
    assign recover_o       = rec_c;
    assign recoverRtr_o    = rec_rtr_c;
    assign recoverCall_o   = rec_call_c;
    assign recoverTarget_o = rec_tgt_c;
    assign callPC_o        = call_pc_c;
`endif

    assign out_valid_o = valid_q;
    assign outPC_o     = pc_q;
    assign outMask_o   = mask_q;
    assign outTag_o    = tag_q;
    assign outTarget_o = tgt_q;
    assign ctiqCount_o = count_c;
    assign ctiqFull_o  = (count_c == PW'(DEPTH));

endmodule
